ahb_apb_bridge_param: RTL and testbench
=======================================

# ahb_apb_bridge_param

Parametrised AHB-Lite-to-APB3 bridge, the successor to the fixed three-slave bridge. It accepts single AHB transfers from the AHB master and converts each into one APB3 SETUP/ACCESS sequence. Slave decode, slave count and address/data widths are configurable. It honours PREADY wait states, maps PSLVERR and decode misses to a two-cycle AHB ERROR response, and aborts hung APB transfers after a configurable timeout.

## Interface
- ADDR_W, 32, address width (haddr, paddr)
- DATA_W, 32, data width (hwdata, hrdata, pwdata, prdata)
- NSLV, 3, number of APB slaves (psel width)
- BASE_ADDR, 32'h8000_0000, start of slave 0 region
- REGION_LOG2, 26, log2 of each slave region size (64 MB)
- TIMEOUT, 16, maximum ACCESS cycles waiting for pready; 0 disables the timeout
- hclk  in  1  clock, rising edge
- hresetn  in  1  asynchronous active-low reset
- hwrite  in  1  AHB write (1) / read (0)
- hreadyin  in  1  AHB bus ready
- htrans  in  2  AHB transfer type; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- haddr  in  ADDR_W  AHB address
- hwdata  in  DATA_W  AHB write data (data phase)
- hreadyout  out  1  bridge ready
- hresp  out  2  00=OKAY, 01=ERROR
- hrdata  out  DATA_W  read data
- psel  out  NSLV  one-hot APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

## Operation
- All outputs are registered. Reset values: hreadyout=1, hresp=00, hrdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, state=IDLE.
- valid = hreadyin & htrans[1] & hreadyout. BUSY and IDLE transfers are ignored with an OKAY response.
- Decode: off = haddr - BASE_ADDR; idx = off >> REGION_LOG2. A hit requires haddr >= BASE_ADDR and idx < NSLV. psel = 1 << idx.
- States:
  - IDLE: hreadyout=1. On valid, latch haddr into paddr and hwrite into pwrite, and set hreadyout=0. Miss -> ERR1. Hit read -> SETUP. Hit write -> WDATA.
  - WDATA: latch hwdata into pwdata -> SETUP.
  - SETUP: psel=one-hot, penable=0 -> ACCESS; the timeout counter is cleared.
  - ACCESS: penable=1.
    - pready & !pslverr: psel=0, penable=0; on a read, hrdata<=prdata; hreadyout=1 -> IDLE.
    - pready & pslverr: psel=0, penable=0, hresp=01 -> ERR1.
    - !pready: the counter increments. When counter reaches TIMEOUT-1 (TIMEOUT≠0), take the pslverr path.
  - ERR1: hreadyout=0, hresp=01 -> IDLE. The first IDLE cycle after ERR1 holds hresp=01 with hreadyout=1, which completes the two-cycle ERROR response. hresp returns to 00 on the following edge.
- paddr, pwrite and pwdata hold their values after completion. hrdata holds until the next read completes. On a write or error, hrdata is unchanged.
- Asserting hresetn low at any point, including mid-ACCESS, immediately forces all reset values. A pending transfer is dropped and no response is given.

## Timing
- Read with zero wait states: hreadyout is low for 3 cycles (SETUP, ACCESS, ACCESS-complete edge). hrdata is valid in the cycle hreadyout returns high.
- Write with zero wait states: hreadyout is low for 4 cycles (WDATA added).
- Each pready=0 cycle in ACCESS adds 1 cycle.
- Decode miss: hreadyout is low for 2 cycles, and psel is never asserted.
- A new valid transfer is accepted in any cycle where hreadyout=1, including the second ERROR cycle.
- psel and penable never assert in the same cycle as a decode miss.

## Test plan
- Write 0x8400_0010 / 0xA5A5_1234, pready=1 -> psel=010; pwrite=1; paddr=0x8400_0010; pwdata=0xA5A5_1234; penable high for exactly 1 cycle; hreadyout low for 4 cycles; hresp=00.
- Read 0x8800_0004, 2 wait states, prdata=0xDEAD_BEEF -> psel=100; hreadyout low for 5 cycles; hrdata=0xDEAD_BEEF; hresp=00.
- Read 0x9000_0000 (miss) -> psel stays 000; hresp=01 for 2 cycles with hreadyout 0 then 1; hrdata unchanged.
- Write 0x8000_0000 with pslverr=1 at pready -> psel=001 for 2 cycles, then the ERROR sequence; a back-to-back read to 0x8000_0004 issued in the second ERROR cycle completes OKAY.
- TIMEOUT=8, pready stuck at 0 -> penable high for 8 cycles, then psel=0 and hresp=01 for 2 cycles; with TIMEOUT=0 the bridge waits indefinitely.
- Assert hresetn low during ACCESS -> all outputs at reset values within the same cycle; a subsequent read to 0x8400_0000 completes normally.

Source files
------------

// File: rtl/ahb_apb_bridge_param.sv
// AHB-Lite to APB3 bridge: one APB SETUP/ACCESS per AHB transfer, parametrised decode,
// PREADY wait states, two-cycle AHB ERROR on PSLVERR, decode miss or ACCESS timeout.
//
// state    | meaning
// S_IDLE   | ready for a transfer; also the second ERROR cycle after S_ERR1
// S_WDATA  | capture AHB write data from the data phase
// S_SETUP  | drive psel, penable low (APB setup phase)
// S_ACCESS | raise penable, then wait for pready or the timeout
// S_ERR1   | first ERROR cycle (hreadyout low, hresp ERROR)
module ahb_apb_bridge_param #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NSLV        = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
    parameter int                REGION_LOG2 = 26,
    parameter int                TIMEOUT     = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hwrite,
    input  logic              hreadyin,
    input  logic [1:0]        htrans,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic [1:0]        hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic [NSLV-1:0]   psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LOAD = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4
    } state_t;

    state_t            state;
    logic [NSLV-1:0]   sel_q;
    logic [CNT_W-1:0]  to_cnt;

    logic              valid;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] idx;
    logic              hit;
    logic [NSLV-1:0]   dec_sel;

    assign valid = hreadyin & htrans[1] & hreadyout;
    assign off   = haddr - BASE_ADDR;
    assign idx   = off >> REGION_LOG2;
    assign hit   = (haddr >= BASE_ADDR) && (idx < ADDR_W'(NSLV));

    always_comb begin
        dec_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            dec_sel[i] = (idx == ADDR_W'(i));
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 2'b00;
            hrdata    <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            sel_q     <= '0;
            to_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    hreadyout <= 1'b1;
                    // hresp is held for one cycle when arriving from S_ERR1 (hreadyout still low)
                    if (hreadyout) begin
                        hresp <= 2'b00;
                    end
                    if (valid) begin
                        paddr     <= haddr;
                        pwrite    <= hwrite;
                        sel_q     <= dec_sel;
                        hreadyout <= 1'b0;
                        if (!hit) begin
                            state <= S_ERR1;
                        end else if (hwrite) begin
                            state <= S_WDATA;
                        end else begin
                            state <= S_SETUP;
                        end
                    end
                end
                S_WDATA: begin
                    pwdata <= hwdata;
                    state  <= S_SETUP;
                end
                S_SETUP: begin
                    psel    <= sel_q;
                    penable <= 1'b0;
                    to_cnt  <= CNT_W'(TO_LOAD);
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (!penable) begin
                        penable <= 1'b1;
                    end else if (pready) begin
                        psel    <= '0;
                        penable <= 1'b0;
                        if (pslverr) begin
                            state <= S_ERR1;
                        end else begin
                            if (!pwrite) begin
                                hrdata <= prdata;
                            end
                            hreadyout <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else if ((TIMEOUT != 0) && (to_cnt == '0)) begin
                        psel    <= '0;
                        penable <= 1'b0;
                        state   <= S_ERR1;
                    end else begin
                        to_cnt <= to_cnt - CNT_W'(1);
                    end
                end
                S_ERR1: begin
                    hreadyout <= 1'b0;
                    hresp     <= 2'b01;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// Bench for ahb_apb_bridge_param: directed and random AHB transfers against a
// transfer-level reference model (decode by division, latency by formula).
module tb_ahb_apb_bridge_param;

    localparam int TO_A = 8;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hwrite = 1'b0;
    logic        hreadyin = 1'b1;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    logic        hreadyout, penable, pwrite;
    logic [1:0]  hresp;
    logic [31:0] hrdata, paddr, pwdata;
    logic [2:0]  psel;

    logic        hreadyout_b, penable_b, pwrite_b;
    logic [1:0]  hresp_b;
    logic [31:0] hrdata_b, paddr_b, pwdata_b;
    logic [2:0]  psel_b;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hrdata = '0;
    logic [31:0] m_pwdata = '0;

    always #5 hclk = ~hclk;

    ahb_apb_bridge_param #(.TIMEOUT(TO_A)) dut (
        .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hreadyin),
        .htrans(htrans), .haddr(haddr), .hwdata(hwdata),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    ahb_apb_bridge_param #(.TIMEOUT(0)) dut0 (
        .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hreadyin),
        .htrans(htrans), .haddr(haddr), .hwdata(hwdata),
        .hreadyout(hreadyout_b), .hresp(hresp_b), .hrdata(hrdata_b),
        .psel(psel_b), .penable(penable_b), .pwrite(pwrite_b), .paddr(paddr_b), .pwdata(pwdata_b),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Slave index 0..2 for a hit, -1 for a miss; 64 MB regions from 0x8000_0000.
    function automatic int model_idx(input logic [31:0] a);
        int q;
        if (a < 32'h8000_0000) return -1;
        q = int'((a - 32'h8000_0000) / 32'h0400_0000);
        return (q < 3) ? q : -1;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_hreadyout"}, 32'(hreadyout), 32'd1);
        chk({tag, "_hresp"},     32'(hresp),     32'd0);
        chk({tag, "_hrdata"},    hrdata,         32'd0);
        chk({tag, "_psel"},      32'(psel),      32'd0);
        chk({tag, "_penable"},   32'(penable),   32'd0);
        chk({tag, "_pwrite"},    32'(pwrite),    32'd0);
        chk({tag, "_paddr"},     paddr,          32'd0);
        chk({tag, "_pwdata"},    pwdata,         32'd0);
        chk({tag, "_b_hreadyout"}, 32'(hreadyout_b), 32'd1);
        chk({tag, "_b_psel"},      32'(psel_b),      32'd0);
        chk({tag, "_b_penable"},   32'(penable_b),   32'd0);
        chk({tag, "_b_hrdata"},    hrdata_b,         32'd0);
    endtask

    // Issues one AHB transfer starting in a cycle where hreadyout is high (called at a negedge),
    // plays the APB slave, and compares the whole transfer against the model. Ends at the
    // negedge of the first cycle with hreadyout high again.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input logic err, input string tag);
        int idx, eff_w, low, pen_cyc, sel_cyc, err_lo, wcnt, exp_low;
        logic eff_err, done, bad;
        logic [2:0] sel_or;
        logic [1:0] end_resp;
        idx = model_idx(addr);
        eff_w = waits;
        eff_err = err;
        if (idx >= 0 && waits >= TO_A) begin
            eff_w = TO_A - 1;
            eff_err = 1'b1;
        end
        bad = (idx < 0) || eff_err;
        hwrite = wr; haddr = addr; htrans = 2'b10; hreadyin = 1'b1;
        @(posedge hclk);
        #1;
        htrans = 2'b00; hwdata = wdata; haddr = $urandom; hwrite = 1'($urandom);
        low = 0; pen_cyc = 0; sel_cyc = 0; err_lo = 0; wcnt = 0;
        sel_or = '0; end_resp = 2'b11; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge hclk);
            if (hreadyout) begin
                done = 1'b1;
                end_resp = hresp;
            end else begin
                low++;
                if (hresp == 2'b01) err_lo++;
            end
            sel_or |= psel;
            if (psel != 3'b000) sel_cyc++;
            if (penable) pen_cyc++;
            pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
            if (penable && psel != 3'b000) begin
                if (wcnt < waits) wcnt++;
                else begin
                    pready = 1'b1; pslverr = err; prdata = rdata;
                end
            end
        end
        pready = 1'b0; pslverr = 1'b0;
        chk({tag, "_complete"}, 32'(done), 32'd1);
        exp_low = (idx < 0) ? 2 : 3 + eff_w + int'(wr) + (eff_err ? 2 : 0);
        chk({tag, "_low_cycles"}, 32'(low), 32'(exp_low));
        chk({tag, "_end_hresp"}, 32'(end_resp), bad ? 32'd1 : 32'd0);
        chk({tag, "_err_low_cycles"}, 32'(err_lo), bad ? 32'd1 : 32'd0);
        chk({tag, "_psel"}, 32'(sel_or), (idx < 0) ? 32'd0 : 32'(1 << idx));
        chk({tag, "_psel_cycles"}, 32'(sel_cyc), (idx < 0) ? 32'd0 : 32'(eff_w + 2));
        chk({tag, "_penable_cycles"}, 32'(pen_cyc), (idx < 0) ? 32'd0 : 32'(eff_w + 1));
        chk({tag, "_paddr"}, paddr, addr);
        chk({tag, "_pwrite"}, 32'(pwrite), 32'(wr));
        if (idx >= 0 && wr) m_pwdata = wdata;
        chk({tag, "_pwdata"}, pwdata, m_pwdata);
        if (idx >= 0 && !wr && !eff_err) m_hrdata = rdata;
        chk({tag, "_hrdata"}, hrdata, m_hrdata);
    endtask

    initial begin
        logic [31:0] a, d;
        int sel, pen_b;

        repeat (3) @(negedge hclk);
        check_reset_values("reset");
        hresetn = 1'b1;
        @(negedge hclk);

        xfer(1'b1, 32'h8400_0010, 32'hA5A5_1234, 32'h0, 0, 1'b0, "wr_s1");
        xfer(1'b0, 32'h8800_0004, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, "rd_s2_ws2");
        xfer(1'b0, 32'h9000_0000, 32'h0, 32'h1234_5678, 0, 1'b0, "rd_miss");
        @(negedge hclk);
        chk("miss_hresp_clear", 32'(hresp), 32'd0);
        xfer(1'b1, 32'h8000_0000, 32'h1111_2222, 32'h0, 0, 1'b1, "wr_slverr");
        xfer(1'b0, 32'h8000_0004, 32'h0, 32'hCAFE_F00D, 0, 1'b0, "rd_b2b");
        xfer(1'b1, 32'h8000_0000 - 32'h4, 32'h5555_AAAA, 32'h0, 0, 1'b0, "wr_below_base");
        xfer(1'b0, 32'h8BFF_FFFC, 32'h0, 32'h0F0F_0F0F, 1, 1'b0, "rd_top_s2");
        xfer(1'b0, 32'h8C00_0000, 32'h0, 32'h7777_7777, 0, 1'b0, "rd_first_miss");

        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 4));
            if (sel < 4) a = 32'h8000_0000 + (32'(sel) << 26) + ($urandom & 32'h03FF_FFFC);
            else a = $urandom & 32'h7FFF_FFFC;
            d = $urandom;
            xfer(1'($urandom), a, d, $urandom, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), $sformatf("rand%0d", n));
            if ($urandom_range(0, 1) == 1) repeat (int'($urandom_range(1, 2))) @(negedge hclk);
        end
        chk("rand_lockstep_hrdata_b", hrdata_b, m_hrdata);

        @(negedge hclk);
        xfer(1'b0, 32'h8400_0100, 32'h0, 32'h0, 1000, 1'b0, "rd_timeout");
        pen_b = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge hclk);
            if (penable_b && !hreadyout_b && psel_b == 3'b010) pen_b++;
        end
        chk("notimeout_still_waiting", 32'(pen_b), 32'd30);
        pready = 1'b1; prdata = 32'h600D_D00D;
        @(negedge hclk);
        pready = 1'b0;
        chk("notimeout_done_hreadyout", 32'(hreadyout_b), 32'd1);
        chk("notimeout_done_hresp", 32'(hresp_b), 32'd0);
        chk("notimeout_done_hrdata", hrdata_b, 32'h600D_D00D);
        chk("timeout_dut_idle_hrdata", hrdata, m_hrdata);

        @(negedge hclk);
        hwrite = 1'b0; haddr = 32'h8800_0000; htrans = 2'b10;
        @(posedge hclk);
        #1;
        htrans = 2'b00;
        for (int c = 0; c < 10 && !penable; c++) @(negedge hclk);
        chk("rst_reached_access", 32'(penable), 32'd1);
        #2;
        hresetn = 1'b0;
        #1;
        m_hrdata = '0;
        m_pwdata = '0;
        check_reset_values("rst_mid_access");
        @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);
        xfer(1'b0, 32'h8400_0000, 32'h0, 32'h0BAD_CAFE, 1, 1'b0, "rd_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
